f_pc_fd_stage: RTL and testbench
================================

// Module: f_pc_fd_stage
// PURPOSE
//  Fetch-stage PC register plus F/D pipeline register of the 5-stage MIPS core with CP0 exceptions.
//  - Each cycle it loads the next-PC produced by the D-stage next-PC logic.
//  - It detects fetch address exceptions (AdEL) and tags delay-slot instructions.
//  - It presents PC, instruction, ExcCode and BD to the D stage.
//  - It implements stall, exception redirect and eret squash.
// PARAMETERS
//  RESET_PC   32'h0000_3000  F_PC value after reset
//  EXC_ENTRY  32'h0000_4180  handler entry loaded on Req
//  TEXT_BASE  32'h0000_3000  lowest legal fetch address
//  TEXT_END   32'h0000_6ffc  highest legal fetch address (inclusive)
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  reset      in   1   synchronous reset, active-low (0 = reset)
//  NPC        in   32  next PC from D-stage next-PC logic
//  Stall      in   1   hazard-unit stall: hold F_PC and F/D register
//  Req        in   1   CP0 interrupt/exception request: redirect to EXC_ENTRY
//  D_is_eret  in   1   instruction in D is eret
//  D_is_jump  in   1   instruction in D is branch/jump; F instr is its delay slot
//  F_Instr_in in   32  instruction word read from IM at F_PC
//  F_PC       out  32  current fetch PC, to IM address
//  D_PC       out  32  PC of instruction in D
//  D_Instr    out  32  instruction in D (0 = nop bubble)
//  D_ExcCode  out  5   exception code carried from F (0 none, 4 AdEL)
//  D_BD       out  1   instruction in D is a delay-slot instruction
// BEHAVIOUR
//  Combinational F-side signals
//  - F_AdEL = (F_PC[1:0]!=0) | (F_PC<TEXT_BASE) | (F_PC>TEXT_END); unsigned 32-bit compares.
//  - F_ExcCode = F_AdEL ? 5'd4 : 5'd0.
//  - F_Instr = F_AdEL ? 32'h0 : F_Instr_in. A faulting fetch never issues its IM word.
//  - F_BD = D_is_jump.
//  Sequential update (posedge clk); priority reset > Req > Stall > eret > normal
//  - reset==0: F_PC<=RESET_PC; D_PC<=0; D_Instr<=0; D_ExcCode<=0; D_BD<=0.
//  - Req: F_PC<=EXC_ENTRY; D_PC<=EXC_ENTRY; D_Instr<=0; D_ExcCode<=0; D_BD<=0.
//    Req overrides Stall.
//  - Stall (no Req): F_PC and all D_* registers hold their values.
//  - D_is_eret (no Req, no Stall): F_PC<=NPC (EPC path). F/D flushed:
//    D_PC<=F_PC, D_Instr<=0, D_ExcCode<=0, D_BD<=0. eret has no delay slot.
//  - normal: F_PC<=NPC; D_PC<=F_PC; D_Instr<=F_Instr; D_ExcCode<=F_ExcCode; D_BD<=F_BD.
//  Latency
//  - NPC reaches F_PC 1 cycle later.
//  - F values reach D_* 1 cycle later.
//  - Bubbles keep a valid D_PC so the macro PC stays defined.
//  Boundary conditions
//  - Misaligned or out-of-range NPC is accepted into F_PC. The fault is reported only through
//    ExcCode; the PC is never masked or clamped.
//  - F_PC wrap at 32'hffff_fffc: no special handling (out of range => AdEL).
//  - Req and Stall in the same cycle: Req wins, and the stalled D instruction is discarded.
//  - Req and D_is_eret in the same cycle: Req wins.
//  - reset deasserted mid-stall: first non-reset cycle uses normal priority, with F_PC=RESET_PC.
// TESTING
//  1 reset=0 for 2 cycles, then 1, NPC=F_PC+4 -> F_PC 0x3000,0x3004,0x3008;
//    D_PC lags by 1 cycle; D_Instr = IM words.
//  2 NPC=0x3002 -> next cycle F_PC=0x3002, F_Instr forced 0;
//    following cycle D_ExcCode=4, D_Instr=0, D_PC=0x3002.
//  3 D_is_jump=1 while F_PC=0x3010 -> next cycle D_BD=1, D_PC=0x3010.
//  4 Stall=1 for 3 cycles with NPC changing -> F_PC, D_PC, D_Instr constant;
//    release -> F_PC=NPC next cycle.
//  5 Req=1 together with Stall=1 -> next cycle F_PC=0x4180, D_PC=0x4180, D_Instr=0, D_BD=0.
//  6 D_is_eret=1, NPC=0x3020 -> next cycle F_PC=0x3020, D_Instr=0, D_ExcCode=0.

Source files
------------

// File: rtl/f_pc_fd_stage.sv
// Fetch PC register and F/D pipeline register for the 5-stage MIPS core.
// Detects fetch AdEL, tags delay slots, handles stall, CP0 redirect and eret squash.
//
// Ports:
//   clk        : clock, all state updates on posedge
//   reset      : synchronous reset, active-low
//   NPC        : next PC from D-stage next-PC logic
//   Stall      : hold F_PC and F/D register
//   Req        : CP0 request, redirect fetch to EXC_ENTRY
//   D_is_eret  : instruction in D is eret (squash F/D)
//   D_is_jump  : instruction in D is branch/jump (F instr is its delay slot)
//   F_Instr_in : IM word read at F_PC
//   F_PC       : current fetch PC
//   D_PC       : PC of instruction in D
//   D_Instr    : instruction in D (0 = bubble)
//   D_ExcCode  : exception code carried from F (0 none, 4 AdEL)
//   D_BD       : instruction in D is a delay-slot instruction
module f_pc_fd_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter logic [31:0] TEXT_END  = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC,
    input  logic        Stall,
    input  logic        Req,
    input  logic        D_is_eret,
    input  logic        D_is_jump,
    input  logic [31:0] F_Instr_in,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] f_pc_q,    f_pc_d;
    logic [31:0] d_pc_q,    d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [4:0]  d_exc_q,   d_exc_d;
    logic        d_bd_q,    d_bd_d;

    logic        f_adel;
    logic [4:0]  f_exc;
    logic [31:0] f_instr;
    logic        f_bd;

    // The PC is never clamped; a bad fetch address only shows up as AdEL
    // and its IM word is replaced by a nop.
    assign f_adel  = (f_pc_q[1:0] != 2'b00) |
                     (f_pc_q < TEXT_BASE) |
                     (f_pc_q > TEXT_END);
    assign f_exc   = f_adel ? EXC_ADEL : EXC_NONE;
    assign f_instr = f_adel ? 32'h0 : F_Instr_in;
    assign f_bd    = D_is_jump;

    always_comb begin
        f_pc_d    = f_pc_q;
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        d_exc_d   = d_exc_q;
        d_bd_d    = d_bd_q;
        if (Req) begin
            // Redirect wins over stall; the stalled D instruction is dropped.
            f_pc_d    = EXC_ENTRY;
            d_pc_d    = EXC_ENTRY;
            d_instr_d = 32'h0;
            d_exc_d   = EXC_NONE;
            d_bd_d    = 1'b0;
        end else if (Stall) begin
            f_pc_d = f_pc_q;
        end else if (D_is_eret) begin
            // eret has no delay slot: squash F but keep a valid D_PC.
            f_pc_d    = NPC;
            d_pc_d    = f_pc_q;
            d_instr_d = 32'h0;
            d_exc_d   = EXC_NONE;
            d_bd_d    = 1'b0;
        end else begin
            f_pc_d    = NPC;
            d_pc_d    = f_pc_q;
            d_instr_d = f_instr;
            d_exc_d   = f_exc;
            d_bd_d    = f_bd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            f_pc_q    <= RESET_PC;
            d_pc_q    <= 32'h0;
            d_instr_q <= 32'h0;
            d_exc_q   <= EXC_NONE;
            d_bd_q    <= 1'b0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_exc_q   <= d_exc_d;
            d_bd_q    <= d_bd_d;
        end
    end

    assign F_PC      = f_pc_q;
    assign D_PC      = d_pc_q;
    assign D_Instr   = d_instr_q;
    assign D_ExcCode = d_exc_q;
    assign D_BD      = d_bd_q;

endmodule

// File: tb/tb_f_pc_fd_stage.sv
// Testbench for f_pc_fd_stage.
// Directed scenarios plus random traffic against a behavioural pipeline model.
module tb_f_pc_fd_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] NPC;
    logic        Stall, Req, D_is_eret, D_is_jump;
    logic [31:0] F_Instr_in;
    logic [31:0] F_PC, D_PC, D_Instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_fpc, m_dpc, m_di;
    logic [4:0]  m_dx;
    logic        m_dbd;

    always #5 clk = ~clk;

    f_pc_fd_stage dut (
        .clk        (clk),
        .reset      (reset),
        .NPC        (NPC),
        .Stall      (Stall),
        .Req        (Req),
        .D_is_eret  (D_is_eret),
        .D_is_jump  (D_is_jump),
        .F_Instr_in (F_Instr_in),
        .F_PC       (F_PC),
        .D_PC       (D_PC),
        .D_Instr    (D_Instr),
        .D_ExcCode  (D_ExcCode),
        .D_BD       (D_BD)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction memory contents: any nonzero word derived from the address.
    function automatic logic [31:0] im(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5a5a, ~pc[15:0]} | 32'h1;
    endfunction

    function automatic bit bad_addr(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
    endfunction

    task automatic check_all();
        chk("F_PC", F_PC, m_fpc);
        chk("D_PC", D_PC, m_dpc);
        chk("D_Instr", D_Instr, m_di);
        chk("D_ExcCode", {27'h0, D_ExcCode}, {27'h0, m_dx});
        chk("D_BD", {31'h0, D_BD}, {31'h0, m_dbd});
    endtask

    // One clock: drive inputs at negedge, update model at posedge, check at +1.
    task automatic step(input logic rst, input logic [31:0] npc,
                        input logic st, input logic rq,
                        input logic er, input logic jp);
        @(negedge clk);
        reset      = rst;
        NPC        = npc;
        Stall      = st;
        Req        = rq;
        D_is_eret  = er;
        D_is_jump  = jp;
        F_Instr_in = im(m_fpc);
        @(posedge clk);
        if (!rst) begin
            m_fpc = 32'h3000; m_dpc = 0; m_di = 0; m_dx = 0; m_dbd = 0;
        end else if (rq) begin
            m_fpc = 32'h4180; m_dpc = 32'h4180; m_di = 0; m_dx = 0; m_dbd = 0;
        end else if (st) begin
            m_fpc = m_fpc;
        end else if (er) begin
            m_dpc = m_fpc; m_fpc = npc; m_di = 0; m_dx = 0; m_dbd = 0;
        end else begin
            m_dpc = m_fpc;
            m_di  = bad_addr(m_fpc) ? 32'h0 : im(m_fpc);
            m_dx  = bad_addr(m_fpc) ? 5'd4 : 5'd0;
            m_dbd = jp;
            m_fpc = npc;
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] hold_pc, hold_dpc, hold_di, n;
        m_fpc = 'x; m_dpc = 'x; m_di = 'x; m_dx = 'x; m_dbd = 'x;

        // 1: reset, then sequential fetch
        step(0, 32'h0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        chk("rst_fpc", F_PC, 32'h3000);
        chk("rst_dinstr", D_Instr, 32'h0);
        for (int i = 0; i < 3; i++) step(1, m_fpc + 4, 0, 0, 0, 0);
        chk("seq_fpc", F_PC, 32'h300c);
        chk("seq_dpc", D_PC, 32'h3008);

        // 2: misaligned fetch
        step(1, 32'h3002, 0, 0, 0, 0);
        chk("mis_fpc", F_PC, 32'h3002);
        step(1, 32'h3010, 0, 0, 0, 0);
        chk("mis_exc", {27'h0, D_ExcCode}, 32'd4);
        chk("mis_instr", D_Instr, 32'h0);
        chk("mis_dpc", D_PC, 32'h3002);

        // 3: delay slot tagging
        step(1, 32'h3014, 0, 0, 0, 1);
        chk("bd_flag", {31'h0, D_BD}, 32'h1);
        chk("bd_dpc", D_PC, 32'h3010);

        // 4: stall holds
        hold_pc = F_PC; hold_dpc = D_PC; hold_di = D_Instr;
        step(1, 32'h3100, 1, 0, 0, 0);
        step(1, 32'h3200, 1, 0, 0, 1);
        step(1, 32'h3300, 1, 0, 0, 0);
        chk("stall_fpc", F_PC, hold_pc);
        chk("stall_dpc", D_PC, hold_dpc);
        chk("stall_di", D_Instr, hold_di);
        step(1, 32'h3400, 0, 0, 0, 0);
        chk("unstall_fpc", F_PC, 32'h3400);

        // 5: Req beats Stall
        step(1, 32'h3500, 1, 1, 0, 1);
        chk("req_fpc", F_PC, 32'h4180);
        chk("req_dpc", D_PC, 32'h4180);
        chk("req_di", D_Instr, 32'h0);

        // 6: eret squash; then Req beats eret
        step(1, 32'h3020, 0, 0, 1, 1);
        chk("eret_fpc", F_PC, 32'h3020);
        chk("eret_di", D_Instr, 32'h0);
        step(1, 32'h3030, 0, 1, 1, 0);
        chk("req_eret", F_PC, 32'h4180);

        // Boundaries: out-of-range and wrap addresses
        step(1, 32'h6ffc, 0, 0, 0, 0);
        step(1, 32'h7000, 0, 0, 0, 0);
        step(1, 32'hffff_fffc, 0, 0, 0, 0);
        chk("oor_exc", {27'h0, D_ExcCode}, 32'd4);
        step(1, 32'h0000_0000, 0, 0, 0, 0);
        step(1, 32'h2ffc, 0, 0, 0, 0);
        // reset released mid-stall
        step(0, 32'h0, 1, 0, 0, 0);
        step(1, 32'h3040, 1, 0, 0, 0);
        chk("rst_stall", F_PC, 32'h3000);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       n = 32'h3000 + ($urandom_range(0, 32'h1000) << 2);
                1:       n = $urandom;
                2:       n = m_fpc + 2;
                3:       n = 32'hffff_fffc;
                default: n = m_fpc + 4;
            endcase
            step($urandom_range(0, 49) != 0, n,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
